// File: rtl/memory_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_port_ctrl_if
// Description : Requester A/B, response and RAM-tile signals of memory_port_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_port_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic                  a_valid;
    logic                  a_ready;
    logic                  a_wen;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;

    logic                  b_valid;
    logic                  b_ready;
    logic                  b_wen;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;

    logic                  rsp_valid;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_done;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_d_in;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_d_out;

    // master: requesters plus the RAM tile; slave: the controller
    modport master (
        output a_valid, a_wen, a_addr, a_wdata,
        output b_valid, b_wen, b_addr, b_wdata,
        output mem_d_out,
        input  a_ready, b_ready,
        input  rsp_valid, rsp_id, rsp_rdata, init_done,
        input  mem_addr, mem_d_in, mem_wen
    );

    modport slave (
        input  a_valid, a_wen, a_addr, a_wdata,
        input  b_valid, b_wen, b_addr, b_wdata,
        input  mem_d_out,
        output a_ready, b_ready,
        output rsp_valid, rsp_id, rsp_rdata, init_done,
        output mem_addr, mem_d_in, mem_wen
    );
endinterface
`default_nettype wire

// File: rtl/memory_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : memory_port_ctrl
// Description : Round-robin two-requester controller for a single-port sync RAM,
//               with optional post-reset clear sweep and tagged read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_port_ctrl #(
    parameter int                  ADDR_WIDTH  = 10,
    parameter int                  DATA_WIDTH  = 8,
    parameter int                  INIT_ENABLE = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  wire logic         memory_port_ctrl_clk,
    input  wire logic         memory_port_ctrl_reset,
    memory_port_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t                c_reset_state = (INIT_ENABLE != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr   = '1;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_rr_last;      // 0 = A granted last, 1 = B
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_d_in;
    logic                  r_rd_valid;
    logic                  r_rd_id;
    logic                  r_rsp_valid;
    logic                  r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_init_done;

    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_mem_wen;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_d_in;
    logic                  w_rd_accept;

    always_ff @(posedge memory_port_ctrl_clk) begin
        if (memory_port_ctrl_reset) begin
            r_state <= c_reset_state;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_a    = 1'b0;
        w_grant_b    = 1'b0;
        w_mem_wen    = 1'b0;
        w_mem_addr   = r_mem_addr;
        w_mem_d_in   = r_mem_d_in;

        case (r_state)
            ST_INIT: begin
                w_mem_wen  = 1'b1;
                w_mem_addr = r_cnt;
                w_mem_d_in = INIT_VALUE;
                if (r_cnt == c_last_addr) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // On contention the requester that did not win last time goes first
                if (bus.a_valid && (!bus.b_valid || r_rr_last)) begin
                    w_grant_a = 1'b1;
                end else if (bus.b_valid) begin
                    w_grant_b = 1'b1;
                end

                if (w_grant_a) begin
                    w_mem_wen  = bus.a_wen;
                    w_mem_addr = bus.a_addr;
                    w_mem_d_in = bus.a_wdata;
                end else if (w_grant_b) begin
                    w_mem_wen  = bus.b_wen;
                    w_mem_addr = bus.b_addr;
                    w_mem_d_in = bus.b_wdata;
                end
            end
            default: begin
                w_state_next = c_reset_state;
            end
        endcase

        // Nothing reaches the RAM or the requesters while reset is held
        if (memory_port_ctrl_reset) begin
            w_grant_a = 1'b0;
            w_grant_b = 1'b0;
            w_mem_wen = 1'b0;
        end
    end

    assign w_rd_accept = (w_grant_a && !bus.a_wen) || (w_grant_b && !bus.b_wen);

    always_ff @(posedge memory_port_ctrl_clk) begin
        if (memory_port_ctrl_reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge memory_port_ctrl_clk) begin
        if (memory_port_ctrl_reset) begin
            r_rr_last <= 1'b1;
        end else if (w_grant_a) begin
            r_rr_last <= 1'b0;
        end else if (w_grant_b) begin
            r_rr_last <= 1'b1;
        end
    end

    // Last driven address/data, held on the RAM pins while idle
    always_ff @(posedge memory_port_ctrl_clk) begin
        if (memory_port_ctrl_reset) begin
            r_mem_addr <= '0;
            r_mem_d_in <= '0;
        end else begin
            r_mem_addr <= w_mem_addr;
            r_mem_d_in <= w_mem_d_in;
        end
    end

    // Read tag travels one stage alongside the RAM access, then captures d_out
    always_ff @(posedge memory_port_ctrl_clk) begin
        if (memory_port_ctrl_reset) begin
            r_rd_valid  <= 1'b0;
            r_rd_id     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rd_valid  <= w_rd_accept;
            r_rd_id     <= w_grant_b;
            r_rsp_valid <= r_rd_valid;
            if (r_rd_valid) begin
                r_rsp_id    <= r_rd_id;
                r_rsp_rdata <= bus.mem_d_out;
            end
        end
    end

    always_ff @(posedge memory_port_ctrl_clk) begin
        if (memory_port_ctrl_reset) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= (w_state_next == ST_RUN);
        end
    end

    assign bus.a_ready   = w_grant_a;
    assign bus.b_ready   = w_grant_b;
    assign bus.mem_wen   = w_mem_wen;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_d_in  = w_mem_d_in;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.init_done = r_init_done;

endmodule
`default_nettype wire
